// File: rtl/wildeq_stim_gen_if.sv
// Stimulus handshake bundle between wildeq_stim_gen (master) and the cosim consumer (slave).
// Control (start/busy/done) rides alongside the vector valid/ready channel.
interface wildeq_stim_gen_if #(
  parameter int WIDTH = 128
);
  logic             start;
  logic             busy;
  logic             done;
  logic             vec_valid;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_val;
  logic [WIDTH-1:0] vec_xz;
  logic [15:0]      vec_idx;

  modport master (
    input  start, vec_ready,
    output busy, done, vec_valid, vec_val, vec_xz, vec_idx
  );

  modport slave (
    output start, vec_ready,
    input  busy, done, vec_valid, vec_val, vec_xz, vec_idx
  );
endinterface

// File: rtl/wildeq_stim_gen.sv
// Reproducible ==? cosim stimulus: directed walk, then seeded LFSR words; WILDEQ_STIM_XZ_EN adds X/Z planes to random words.
// First vector one cycle after start, directed vectors back-to-back, WIDTH/32 idle cycles per random vector; outputs hold while vec_ready is low.
module wildeq_stim_gen #(
  parameter int          WIDTH = 128,
  parameter int          NRAND = 256,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst,
  wildeq_stim_gen_if.master bus
);

  localparam int              NW       = WIDTH / 32;
  localparam int              WW       = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [31:0]     SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0]     LAST_DIR = 16'(WIDTH + 1);
  localparam logic [31:0]     NRAND_L  = 32'(NRAND);
  localparam logic [WW-1:0]   LAST_W   = WW'(NW - 1);

  typedef enum logic [2:0] {IDLE, DIR, FILL, PRES, DONE} state_t;

  state_t           state, state_n;
  logic [31:0]      lfsr, lfsr_n;
  logic [WW-1:0]    wcnt;
  logic [31:0]      rcnt;
  logic [WIDTH-1:0] val_q, dir_n;
  logic [15:0]      idx_q, idx_inc;
  logic             valid, busy, done, xfer, launch;

  assign lfsr_n  = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? 32'h0040_0007 : 32'h0);
  assign idx_inc = idx_q + 16'd1;
  assign xfer    = valid & bus.vec_ready;
  assign launch  = bus.start & ((state == IDLE) | (state == DONE));

  // Next directed vector, selected by the index it will carry.
  always_comb begin
    dir_n = '0;
    for (int b = 0; b < WIDTH; b++) begin
      dir_n[b] = (idx_inc == 16'(b + 2)) || (idx_inc == 16'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    valid   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_n = DIR;
      end
      DIR: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (xfer && idx_q == LAST_DIR) state_n = (NRAND_L != 32'd0) ? FILL : DONE;
      end
      FILL: begin
        busy = 1'b1;
        if (wcnt == LAST_W) state_n = PRES;
      end
      PRES: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (xfer) state_n = ((rcnt + 32'd1) < NRAND_L) ? FILL : DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) state_n = DIR;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr  <= SEED_EFF;
      wcnt  <= '0;
      rcnt  <= '0;
      val_q <= '0;
      idx_q <= '0;
    end else if (launch) begin
      lfsr  <= SEED_EFF;
      wcnt  <= '0;
      rcnt  <= '0;
      val_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        DIR: begin
          if (xfer) begin
            idx_q <= idx_inc;
            if (idx_q != LAST_DIR) val_q <= dir_n;
          end
        end
        FILL: begin
          lfsr                      <= lfsr_n;
          val_q[int'(wcnt)*32 +: 32] <= lfsr_n;
          wcnt                      <= (wcnt == LAST_W) ? '0 : wcnt + WW'(1);
        end
        PRES: begin
          if (xfer) begin
            idx_q <= idx_inc;
            rcnt  <= rcnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WILDEQ_STIM_XZ_EN
  logic [WIDTH-1:0] xz_q;

  // Rotated self-AND marks about a quarter of each random word as X/Z.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      xz_q <= '0;
    end else if (state == FILL) begin
      xz_q[int'(wcnt)*32 +: 32] <= lfsr_n & {lfsr_n[15:0], lfsr_n[31:16]};
    end
  end

  assign bus.vec_xz = xz_q;
`else
  assign bus.vec_xz = '0;
`endif

  assign bus.vec_valid = valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.vec_val   = val_q;
  assign bus.vec_idx   = idx_q;

endmodule

// File: tb/tb_wildeq_stim_gen.sv
// Scoreboard bench for wildeq_stim_gen: expected stream queued at start, popped on every transfer.
module tb_wildeq_stim_gen;

  localparam int W  = 128;
  localparam int NR = 3;
`ifdef WILDEQ_STIM_XZ_EN
  localparam logic [31:0] SEED = 32'h0001_0001;
`else
  localparam logic [31:0] SEED = 32'h0000_0001;
`endif

  typedef struct {
    logic [15:0]  idx;
    logic [W-1:0] val;
    logic [W-1:0] xz;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic ready;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  int           mcyc, nxfer, n5, last_xfer, done_cyc, gap;
  logic         pv, pr, pdone;
  logic [W-1:0] pval, pxz;
  logic [15:0]  pidx;

  wildeq_stim_gen_if #(.WIDTH(W)) bus ();

  assign bus.start     = start;
  assign bus.vec_ready = ready;

  wildeq_stim_gen #(
    .WIDTH (W),
    .NRAND (NR),
    .SEED  (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_stream();
    exp_t        e;
    logic [31:0] s;
    for (int i = 0; i < W + 2; i++) begin
      e.idx = 16'(i);
      e.xz  = '0;
      e.val = '0;
      if (i == 1) e.val = '1;
      else if (i >= 2) e.val[i-2] = 1'b1;
      exp_q.push_back(e);
    end
    s = (SEED == 32'd0) ? 32'd1 : SEED;
    for (int r = 0; r < NR; r++) begin
      e.idx = 16'(W + 2 + r);
      e.val = '0;
      e.xz  = '0;
      for (int w = 0; w < W / 32; w++) begin
        s = {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0);
        e.val[w*32 +: 32] = s;
`ifdef WILDEQ_STIM_XZ_EN
        e.xz[w*32 +: 32] = s & {s[15:0], s[31:16]};
`endif
      end
      exp_q.push_back(e);
    end
  endtask

  // Called at the falling edge, away from the active edge.
  task automatic sample();
    exp_t e;
    mcyc++;
    if (bus.vec_valid && bus.vec_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_xfer", W'(bus.vec_idx), W'(16'hffff));
      end else begin
        e = exp_q.pop_front();
        chk("idx", W'(bus.vec_idx), W'(e.idx));
        chk("val", bus.vec_val, e.val);
        chk("xz", bus.vec_xz, e.xz);
      end
      if (bus.vec_idx == 16'd5) n5++;
      if (bus.vec_idx == 16'(W + 2)) begin
`ifdef WILDEQ_STIM_XZ_EN
        chk("rand0_word_val", W'(bus.vec_val[31:0]), W'(32'h0002_0002));
        chk("rand0_word_xz", W'(bus.vec_xz[31:0]), W'(32'h0002_0002));
`else
        chk("rand0_const", bus.vec_val, 128'h00000010_00000008_00000004_00000002);
`endif
      end
      nxfer++;
      last_xfer = mcyc;
    end
    if (pv && !pr) begin
      chk("hold_valid", W'(bus.vec_valid), W'(1));
      chk("hold_val", bus.vec_val, pval);
      chk("hold_xz", bus.vec_xz, pxz);
      chk("hold_idx", W'(bus.vec_idx), W'(pidx));
    end
    if (bus.busy && !bus.vec_valid) begin
      gap++;
    end else if (bus.vec_valid) begin
      if (gap != 0) chk("valid_gap", W'(gap), W'(W / 32));
      gap = 0;
    end
    if (bus.done && !pdone) done_cyc = mcyc;
    pv    = bus.vec_valid;
    pr    = bus.vec_ready;
    pval  = bus.vec_val;
    pxz   = bus.vec_xz;
    pidx  = bus.vec_idx;
    pdone = bus.done;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_valid"}, W'(bus.vec_valid), W'(0));
    chk({pfx, "_busy"}, W'(bus.busy), W'(0));
    chk({pfx, "_done"}, W'(bus.done), W'(0));
    chk({pfx, "_val"}, bus.vec_val, W'(0));
    chk({pfx, "_xz"}, bus.vec_xz, W'(0));
    chk({pfx, "_idx"}, W'(bus.vec_idx), W'(0));
  endtask

  task automatic run_stream(input bit bp, input bit poke, input bit abort);
    int cyc     = 0;
    int bp_left = 5;
    bit poked   = 0;
    bit aborted = 0;
    push_stream();
    nxfer     = 0;
    n5        = 0;
    gap       = 0;
    pv        = 1'b0;
    pr        = 1'b1;
    pdone     = bus.done;
    done_cyc  = -1;
    last_xfer = -2;
    ready     = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_valid", W'(bus.vec_valid), W'(1));
    chk("start_busy", W'(bus.busy), W'(1));
    chk("start_idx", W'(bus.vec_idx), W'(0));
    while (!bus.done && cyc < 3000) begin
      ready = 1'b1;
      start = 1'b0;
      if (bp && bus.vec_valid && bus.vec_idx == 16'd5 && bp_left > 0) begin
        ready = 1'b0;
        bp_left--;
      end
      if (poke && !poked && bus.vec_idx == 16'd20) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (abort && bus.vec_idx == 16'(W + 3) && bus.busy && !bus.vec_valid) begin
        rst = 1'b1;
        @(negedge clk); sample();
        @(posedge clk); #1;
        check_zero("abort");
        rst = 1'b0;
        exp_q.delete();
        gap     = 0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk); sample();
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    if (abort) begin
      chk("abort_hit", W'(aborted), W'(1));
    end else begin
      @(negedge clk); sample();
      chk("done_timeout", W'(cyc < 3000), W'(1));
      chk("done_after_last", W'(done_cyc), W'(last_xfer + 1));
      chk("done_busy", W'(bus.busy), W'(0));
      chk("done_valid", W'(bus.vec_valid), W'(0));
      chk("xfer_count", W'(nxfer), W'(W + 2 + NR));
      chk("queue_empty", W'(exp_q.size()), W'(0));
      if (bp) chk("idx5_xfers", W'(n5), W'(1));
    end
  endtask

  initial begin
    mcyc  = 0;
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Full stream with a 5-cycle stall on idx 5 and a start pulse while busy.
    run_stream(1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", W'(bus.done), W'(1));

    // Restart from DONE, then abort in FILL of the second random vector.
    run_stream(1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_zero("post_abort_idle");

    // From IDLE after abort, and again from DONE: identical streams.
    run_stream(1'b0, 1'b0, 1'b0);
    run_stream(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
